// File: rtl/core8_pkg.sv
// core8_pkg: shared types and defaults for the core8 fetch path.
package core8_pkg;
  localparam int         INST_W       = 16;
  localparam int         PC_W_DEF     = 8;
  localparam logic [7:0] RESET_PC_DEF = 8'h00;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} fetch_state_e;
endpackage

// File: rtl/core8_fetch_fifo.sv
// core8_fetch_fifo: DEPTH-entry FIFO of {pc, inst} with flush, count and head outputs.
module core8_fetch_fifo import core8_pkg::*; #(
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [INST_W-1:0] i_inst,
  output logic [1:0]        o_count,
  output logic              o_valid,
  output logic [PC_W-1:0]   o_pc,
  output logic [INST_W-1:0] o_inst
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [PC_W-1:0]   r_pc   [DEPTH];
  logic [INST_W-1:0] r_inst [DEPTH];
  logic [PW-1:0]     r_rd, r_wr;
  logic [1:0]        r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_pc[k]   <= '0;
        r_inst[k] <= '0;
      end
    end else if (i_push && !i_flush) begin
      r_pc[r_wr]   <= i_pc;
      r_inst[r_wr] <= i_inst;
    end
  end
  // Writing into the head slot while it is popped is safe: the head is read from the old contents.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr == LAST ? '0 : r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd == LAST ? '0 : r_rd + 1'b1;
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end
  assign o_count = r_count;
  assign o_valid = r_count != '0;
  assign o_pc    = r_pc[r_rd];
  assign o_inst  = r_inst[r_rd];
endmodule

// File: rtl/core8_ifetch.sv
// core8_ifetch: program counter, memory req/ack fetch FSM and prefetch buffer for the 8-bit core.
// CORE8_IFETCH_PREFETCH_EN enables DEPTH-entry prefetch; otherwise strict fetch-one, consume-one.
module core8_ifetch import core8_pkg::*; #(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid,
  input  logic              inst_take,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc
);
`ifdef CORE8_IFETCH_PREFETCH_EN
  localparam int D = DEPTH;
`else
  localparam int D = DEPTH < 1 ? DEPTH : 1;
`endif
  localparam logic [1:0] D_L = 2'(D);
  fetch_state_e    r_state, w_state_nxt;
  logic [PC_W-1:0] r_fetch_pc, w_pc_nxt, r_mem_addr;
  logic            r_mem_req, w_push, w_pop, w_issue;
  logic [1:0]      w_count, w_count_nxt;
  assign w_pop       = inst_take && inst_valid && !redirect;
  assign w_push      = r_state == S_WAIT && mem_ack && !redirect;
  assign w_count_nxt = w_count + 2'(w_push) - 2'(w_pop);
  // Issue looks at next-cycle occupancy so a take and ack in the same cycle keep fetch streaming.
  assign w_issue     = !redirect && (r_state == S_IDLE || w_push) && w_count_nxt < D_L;
  always_comb begin
    w_pc_nxt    = redirect ? redirect_pc : w_push ? r_fetch_pc + 1'b1 : r_fetch_pc;
    w_state_nxt = w_issue ? S_WAIT :
                  (r_state == S_WAIT && !mem_ack) ? (redirect ? S_DISCARD : S_WAIT) :
                  (r_state == S_DISCARD && !mem_ack) ? S_DISCARD : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_pc_nxt;
      r_mem_req  <= w_state_nxt != S_IDLE;
      if (w_issue) r_mem_addr <= w_pc_nxt;
    end
  end
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  core8_fetch_fifo #(.PC_W(PC_W), .DEPTH(D)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_pc    (r_fetch_pc),
    .i_inst  (mem_rdata),
    .o_count (w_count),
    .o_valid (inst_valid),
    .o_pc    (inst_pc),
    .o_inst  (inst)
  );
endmodule

// File: tb/tb_core8_ifetch.sv
// tb_core8_ifetch: directed bench for core8_ifetch with a latency-programmable memory and pc scoreboard.
module tb_core8_ifetch;
`ifdef CORE8_IFETCH_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1, mem_ack = 1'b0, inst_take = 1'b0, redirect = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [7:0]  redirect_pc = '0;
  logic        mem_req, inst_valid;
  logic [7:0]  mem_addr, inst_pc;
  logic [15:0] inst;
  int n_checks = 0, n_err = 0, n_acks = 0, n_deliv = 0, lat = 0, cnt = 0;
  logic [7:0] held = '0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  core8_ifetch dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_take(inst_take), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {~a, a ^ 8'h5A};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_from(input logic [7:0] a);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(a + 8'(i));
  endtask

  // Memory: acks a request after lat extra cycles; address must hold until the ack.
  initial forever begin
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    if (rst) cnt = 0;
    else if (mem_req) begin
      if (cnt == 0) held = mem_addr;
      else chk("addr_stable", 32'(mem_addr), 32'(held));
      if (cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        n_acks++;
        cnt = 0;
      end else cnt++;
    end
  end

  // Scoreboard: every consumed head must match the next expected pc and its memory word.
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    if (!rst && !redirect && inst_valid && inst_take) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("inst_pc", 32'(inst_pc), 32'(e));
        chk("inst", 32'(inst), 32'(mem_word(e)));
      end
      n_deliv++;
    end
`ifndef CORE8_IFETCH_PREFETCH_EN
    if (!rst) chk("no_req_while_valid", 32'(mem_req && inst_valid), 32'd0);
`endif
  end

  initial begin
    int n, a0, d0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'h00);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", 32'(inst), 32'h0000);
    chk("rst_pc", 32'(inst_pc), 32'h00);
    expect_from(8'h00);
    inst_take = 1'b1;
    lat = 0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("req_c1", 32'(mem_req), 32'd0);
    chk("valid_c1", 32'(inst_valid), 32'd0);
    @(negedge clk);
    chk("req_c2", 32'(mem_req), 32'd1);
    chk("addr_c2", 32'(mem_addr), 32'h00);
    chk("valid_c2", 32'(inst_valid), 32'd0);
    @(negedge clk);
    chk("valid_c3", 32'(inst_valid), 32'd1);
    chk("pc_c3", 32'(inst_pc), 32'h00);
    n = 32'(inst_valid && inst_take);
    repeat (19) begin
      @(negedge clk);
      n += 32'(inst_valid && inst_take);
    end
    chk("throughput", 32'(n), PF ? 32'd20 : 32'd10);

    step();
    rst = 1'b1;
    inst_take = 1'b0;
    step();
    step();
    expect_from(8'h00);
    rst = 1'b0;
    a0 = n_acks;
    repeat (10) step();
    chk("stall_acks", 32'(n_acks - a0), PF ? 32'd2 : 32'd1);
    @(negedge clk);
    chk("stall_req", 32'(mem_req), 32'd0);
    chk("stall_valid", 32'(inst_valid), 32'd1);
    chk("stall_pc", 32'(inst_pc), 32'h00);
    step();
    inst_take = 1'b1;
    a0 = n_acks;
    step();
    inst_take = 1'b0;
    repeat (8) step();
    chk("one_take_acks", 32'(n_acks - a0), 32'd1);
    @(negedge clk);
    chk("one_take_req", 32'(mem_req), 32'd0);

    step();
    redirect = 1'b1;
    redirect_pc = 8'hFE;
    inst_take = 1'b1;
    expect_from(8'hFE);
    d0 = n_deliv;
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("wrap_flush_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 40 && n_deliv - d0 < 3; i++) step();
    chk("wrap_done", 32'(n_deliv - d0 >= 3), 32'd1);

    lat = 3;
    for (int i = 0; i < 40 && !(mem_req && cnt == 1); i++) step();
    chk("found_wait", 32'(mem_req && cnt == 1), 32'd1);
    redirect = 1'b1;
    redirect_pc = 8'h40;
    expect_from(8'h40);
    a0 = n_acks;
    d0 = n_deliv;
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("disc_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 20 && n_acks == a0; i++) step();
    chk("disc_ack_seen", 32'(n_acks - a0), 32'd1);
    step();
    chk("disc_idle_req", 32'(mem_req), 32'd0);
    chk("disc_idle_valid", 32'(inst_valid), 32'd0);
    step();
    chk("disc_new_req", 32'(mem_req), 32'd1);
    chk("disc_new_addr", 32'(mem_addr), 32'h40);
    chk("disc_no_stale", 32'(n_deliv - d0), 32'd0);
    for (int i = 0; i < 40 && n_deliv - d0 < 2; i++) step();
    chk("disc_deliv", 32'(n_deliv - d0 >= 2), 32'd1);

    lat = 2;
    inst_take = 1'b0;
    repeat (30) step();
    @(negedge clk);
    chk("fill_req", 32'(mem_req), 32'd0);
    chk("fill_valid", 32'(inst_valid), 32'd1);
    step();
    inst_take = 1'b1;
    step();
    inst_take = 1'b0;
    for (int i = 0; i < 20 && !mem_ack; i++) step();
    chk("found_ack", 32'(mem_ack), 32'd1);
    redirect = 1'b1;
    redirect_pc = 8'h80;
    inst_take = 1'b1;
    expect_from(8'h80);
    d0 = n_deliv;
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(inst_valid), 32'd0);
    chk("flush_deliv", 32'(n_deliv - d0), 32'd0);
    lat = 0;
    for (int i = 0; i < 40 && n_deliv - d0 < 3; i++) step();
    chk("flush_restart", 32'(n_deliv - d0 >= 3), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
